// File: rtl/des_sbox_unit.sv
// DES S-box substitution stage: maps the 48-bit keyed half-block to the 32-bit
// pre-permutation value, performing LANES S-box lookups per clock.
module des_sbox_unit #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int N  = 8 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
            $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // Entry index is {box[2:0], row[1:0], col[3:0]}; S1..S8 in order, 16 entries per row.
    localparam logic [3:0] SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [47:0]     data_q, data_d;
    logic [31:0]     res_q, res_d;

    logic [2:0]      box_idx   [LANES];
    logic [5:0]      chunk_lsb [LANES];
    logic [5:0]      chunk     [LANES];
    logic [3:0]      nib       [LANES];

    // Box b sits at input bit 6*(7-b) and output nibble 4*(7-b); 7-b is ~b for 3 bits.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign box_idx[gi]   = 3'(int'(cnt_q) * LANES + gi);
            assign chunk_lsb[gi] = {1'b0, ~box_idx[gi], 2'b00} + {2'b00, ~box_idx[gi], 1'b0};
            assign chunk[gi]     = data_q[chunk_lsb[gi] +: 6];
            assign nib[gi]       = SBOX[{box_idx[gi], chunk[gi][5], chunk[gi][0], chunk[gi][4:1]}];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        res_d    = res_q;
        in_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    res_d[{~box_idx[i], 2'b00} +: 4] = nib[i];
                end
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        data_d  = in_data;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign out_data  = res_q;

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit: one harness per LANES value (1, 2, 4, 8), each with
// directed words, a backpressure and reset scenario, and a random handshake stream.
module tb_des_sbox_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam int SB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    function automatic logic [31:0] f_ref(input logic [47:0] x);
        logic [31:0] r;
        int k, row, col;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            k   = int'((x >> (42 - 6 * b)) & 48'h3F);
            row = ((k >> 5) & 1) * 2 + (k & 1);
            col = (k >> 1) & 15;
            r   = (r << 4) | 32'(SB[b][row][col]);
        end
        return r;
    endfunction

    task automatic check(input int lanes, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL L%0d %s actual=%0h required=%0h", lanes, nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int L = 1 << gi;
        localparam int N = 8 / L;

        logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
        logic [47:0] in_data;
        logic [31:0] out_data;

        bit          done_flag = 1'b0;
        bit          chk_en    = 1'b0;
        bit          rand_done = 1'b0;
        bit          m_pending = 1'b0;
        bit          m_zero    = 1'b1;
        bit          m_fire, m_acc;
        int          m_remain  = 0;
        logic [47:0] m_word    = '0;
        int          n_acc     = 0;
        int          n_out     = 0;

        des_sbox_unit #(.LANES(L)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data),
            .busy     (busy)
        );

        // Timing model: an accepted word becomes visible N cycles later and waits for out_ready.
        always @(negedge clk) begin
            if (chk_en) begin
                check(L, "out_valid", out_valid, m_pending && m_remain == 0);
                check(L, "busy", busy, m_pending && m_remain > 0);
                check(L, "in_ready", in_ready, !m_pending || (m_remain == 0 && out_ready));
                if (m_pending && m_remain == 0) begin
                    check(L, "out_data", out_data, f_ref(m_word));
                end else if (!m_pending && m_zero) begin
                    check(L, "out_data_reset", out_data, 0);
                end
            end
            if (rst) begin
                m_pending = 1'b0;
                m_zero    = 1'b1;
            end else begin
                m_fire = m_pending && m_remain == 0 && out_ready;
                m_acc  = in_valid && (!m_pending || m_fire);
                if (m_fire) begin
                    m_pending = 1'b0;
                    n_out++;
                end else if (m_pending && m_remain > 0) begin
                    m_remain--;
                end
                if (m_acc) begin
                    m_pending = 1'b1;
                    m_remain  = N;
                    m_word    = in_data;
                    m_zero    = 1'b0;
                    n_acc++;
                end
            end
        end

        task automatic send_word(input logic [47:0] w);
            int t;
            in_valid = 1'b1;
            in_data  = w;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check(L, "accept_timeout", 0, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic wait_valid(output int lat);
            lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
        endtask

        task automatic drain();
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        endtask

        task automatic expect_result(input logic [31:0] exp, input string nm);
            int lat;
            wait_valid(lat);
            check(L, {nm, "_latency"}, lat, N);
            check(L, nm, out_data, exp);
            drain();
        endtask

        initial begin
            int          lat, e, rc, g, cyc;
            logic [47:0] w, w2;
            logic [31:0] fr;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            chk_en = 1'b1;
            check(L, "rst_in_ready", in_ready, 1);
            check(L, "rst_out_valid", out_valid, 0);
            check(L, "rst_out_data", out_data, 0);
            check(L, "rst_busy", busy, 0);

            send_word(48'h0);
            expect_result(32'hEFA72C4D, "all_zero");
            send_word(48'hFFFFFFFFFFFF);
            expect_result(32'hD9CE3DCB, "all_ones");

            for (int k = 0; k < 64; k++) begin
                w = 48'(k) << 6;
                send_word(w);
                wait_valid(lat);
                check(L, "s7_latency", lat, N);
                check(L, "s7_other_nibbles", out_data & 32'hFFFFFF0F, 32'hEFA72C0D);
                fr = f_ref(w);
                check(L, "s7_model", out_data[7:4], fr[7:4]);
                case (k)
                    0:       e = 4;
                    1:       e = 13;
                    32:      e = 1;
                    63:      e = 12;
                    default: e = -1;
                endcase
                if (e >= 0) check(L, "s7_literal", out_data[7:4], e);
                drain();
            end

            w  = {16'($urandom), $urandom};
            w2 = {16'($urandom), $urandom};
            send_word(w);
            wait_valid(lat);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check(L, "bp_out_valid", out_valid, 1);
                check(L, "bp_out_data", out_data, f_ref(w));
                check(L, "bp_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = w2;
            @(negedge clk);
            check(L, "bp_accept_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check(L, "bp_busy_next", busy, 1);
            expect_result(f_ref(w2), "bp_second");

            rc = (N > 3) ? 3 : N - 1;
            send_word(48'h0123456789AB);
            repeat (rc) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check(L, "midrst_in_ready", in_ready, 1);
            check(L, "midrst_out_valid", out_valid, 0);
            check(L, "midrst_out_data", out_data, 0);
            check(L, "midrst_busy", busy, 0);
            send_word(48'h0);
            expect_result(32'hEFA72C4D, "post_reset_zero");

            n_acc = 0;
            n_out = 0;
            fork
                begin
                    for (int i = 0; i < 1000; i++) begin
                        g = $urandom_range(0, 2);
                        repeat (g) begin
                            @(posedge clk);
                            #1;
                        end
                        send_word({16'($urandom), $urandom});
                    end
                    rand_done = 1'b1;
                end
                begin
                    cyc = 0;
                    while (!rand_done && cyc < 60000) begin
                        out_ready = 1'($urandom_range(0, 1));
                        @(posedge clk);
                        #1;
                        cyc++;
                    end
                end
            join
            out_ready = 1'b1;
            repeat (N + 3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            check(L, "stream_words_accepted", n_acc, 1000);
            check(L, "stream_words_delivered", n_out, n_acc);
            done_flag = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_lane[0].done_flag && g_lane[1].done_flag && g_lane[2].done_flag &&
                 g_lane[3].done_flag) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        check(0, "global_timeout", cyc < 90000, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_sbox_unit.md
# des_sbox_unit

Parametrised DES substitution stage. It takes the 48-bit expanded-and-keyed half-block of one Feistel round and applies all eight DES S-boxes (S1..S8), producing the 32-bit value fed to the P permutation. Work is time-multiplexed over `LANES` S-box lookups per clock, trading area against latency. Valid/ready handshakes on both sides let it sit between the key-mixing XOR stage and the P-box register in the round datapath.

## Interface
- `LANES`, default 2: S-box lookups performed per clock. Legal values are 1, 2, 4, 8; any other value is a elaboration error.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` is presented.
- `in_ready`  out  1  unit accepts `in_data` this cycle.
- `in_data`  in  48  bits [48:1]. [48:43] feeds S1, [42:37] S2, …, [6:1] S8.
- `out_valid`  out  1  `out_data` holds a completed result.
- `out_ready`  in  1  downstream consumes the result.
- `out_data`  out  32  bits [32:1]. [32:29] holds S1, …, [4:1] holds S8.
- `busy`  out  1  high in RUN.

## Operation
- Each S-box lookup takes a 6-bit chunk b6..b1. Row = {b6,b1}, column = b5..b2. Tables are the standard FIPS 46-3 S1..S8.
- N = 8/LANES processing cycles per word.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_data`, clear the chunk counter, and go to RUN.
  - RUN: counter c runs 0..N-1. Each cycle, look up S-boxes c·LANES+1 … c·LANES+LANES and write their nibbles into the result register. At c=N-1, go to DONE.
  - DONE: `out_valid`=1; `out_data` is stable.
    - `out_ready`=1 and `in_valid`=0: go to IDLE.
    - `out_ready`=1 and `in_valid`=1: capture the new word and go directly to RUN (back-to-back).
    - `out_ready`=0: hold.
- `in_ready` = (state==IDLE) or (state==DONE and `out_ready`).
- The captured input register is not modified in RUN, so `in_data` may change after acceptance.
- Result nibbles not yet written hold stale values internally. `out_data` is only meaningful while `out_valid`=1.
- Reset (any state, including mid-RUN or DONE with `out_ready`=0):
  - State goes to IDLE; the counter, result register and captured input clear to 0.
  - The in-flight word is dropped.
- Reset values: `in_ready`=1 on the first cycle after reset; `out_valid`=0, `out_data`=0, `busy`=0.

## Timing
- Accept at edge T0. RUN occupies edges T1..TN. `out_valid` rises after edge TN, so it is visible in cycle N after acceptance:
  - LANES=8: latency 1
  - LANES=4: latency 2
  - LANES=2: latency 4
  - LANES=1: latency 8
- Throughput with `out_ready` held at 1 and `in_valid` held at 1: one word per N+1 cycles.
- `in_ready` depends combinationally on `out_ready` only in DONE. There is no other input-to-output combinational path.
- `out_data` and `out_valid` are driven from registers.

## Test plan
- All-zero input, LANES=2: `in_data`=48'h0 → after 4 cycles `out_valid`=1, `out_data`=32'hEFA72C4D.
- All-ones input, LANES=1, 8 and 4: `in_data`=48'hFFFFFFFFFFFF → `out_data`=32'hD9CE3DCB. Latency is 8, 1 and 2 cycles respectively.
- Single-box sweep:
  - For each k in 0..63, place k in the S7 slot ([12:7]) with other chunks 0.
  - Expect `out_data`[8:5] = S7(k); e.g. k=0→4, 1→13, 32→1, 63→12.
  - Other nibbles stay at their zero-input values.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_data`, `out_valid` stable and `in_ready`=0. Then raise `out_ready` together with `in_valid` → new word accepted the same cycle, `busy`=1 next cycle.
- Reset mid-RUN, LANES=1, asserted at c=3 → next cycle state IDLE, `out_valid`=0, `out_data`=0, `in_ready`=1. A following all-zero word still yields 32'hEFA72C4D.
- Random stream: 1000 words with random `in_valid`/`out_ready` → outputs match a reference model in order, with no drops or duplicates.
